// File: rtl/spdif_pkg.sv
// Shared types and default timing for the S/PDIF receive path.
// Pulse classes, preamble kinds and the half-cell width thresholds at 98.304 MHz / 48 kHz.
package spdif_pkg;

  typedef enum logic [1:0] {
    PRE_B = 2'd0,
    PRE_M = 2'd1,
    PRE_W = 2'd2
  } preamble_t;

  typedef enum logic [1:0] {
    P1   = 2'd0,
    P2   = 2'd1,
    P3   = 2'd2,
    PERR = 2'd3
  } pulse_class_t;

  typedef struct packed {
    logic      hit;
    preamble_t kind;
  } pre_match_t;

  localparam int DEF_UI_CLKS    = 16;
  localparam int DEF_SHORT_MIN  = 4;
  localparam int DEF_SHORT_MAX  = DEF_UI_CLKS + DEF_UI_CLKS / 2;
  localparam int DEF_MEDIUM_MAX = 2 * DEF_UI_CLKS + DEF_UI_CLKS / 2;
  localparam int DEF_LONG_MAX   = 3 * DEF_UI_CLKS + DEF_UI_CLKS / 2;
  localparam int DEF_LOCK_COUNT = 4;

  // Preamble width sequences, first pulse in the top two bits.
  localparam logic [7:0] PAT_B = 8'b10_00_00_10;
  localparam logic [7:0] PAT_M = 8'b10_10_00_00;
  localparam logic [7:0] PAT_W = 8'b10_01_00_01;

  function automatic pre_match_t match_preamble(input logic [7:0] seq);
    pre_match_t m;
    m.hit  = 1'b1;
    m.kind = PRE_B;
    if (seq == PAT_B)      m.kind = PRE_B;
    else if (seq == PAT_M) m.kind = PRE_M;
    else if (seq == PAT_W) m.kind = PRE_W;
    else                   m.hit  = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/spdif_pulse_timer.sv
// Synchronises the S/PDIF line, measures the time between transitions and
// classifies each completed pulse as 1, 2 or 3 UI (or an error).
module spdif_pulse_timer
  import spdif_pkg::*;
#(
  parameter int SHORT_MIN  = DEF_SHORT_MIN,
  parameter int SHORT_MAX  = DEF_SHORT_MAX,
  parameter int MEDIUM_MAX = DEF_MEDIUM_MAX,
  parameter int LONG_MAX   = DEF_LONG_MAX
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         spdif_async,
  output pulse_class_t pulse_class,
  output logic         class_strobe,
  output logic         timeout
);

  localparam int CW = $clog2(LONG_MAX + 2);

  // [0],[1] synchroniser, [2] previous synchronised sample
  logic [2:0]    sync_q;
  logic          edge_det;
  logic [CW-1:0] width_cnt;
  pulse_class_t  cls_c;

  assign edge_det = sync_q[1] ^ sync_q[2];
  assign timeout  = (width_cnt == CW'(LONG_MAX + 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      width_cnt <= '0;
    end else begin
      sync_q <= {sync_q[1:0], spdif_async};
      if (edge_det)
        width_cnt <= CW'(1);
      else if (!timeout)
        width_cnt <= width_cnt + CW'(1);
    end
  end

  always_comb begin
    cls_c = PERR;
    if (width_cnt < CW'(SHORT_MIN))        cls_c = PERR;
    else if (width_cnt <= CW'(SHORT_MAX))  cls_c = P1;
    else if (width_cnt <= CW'(MEDIUM_MAX)) cls_c = P2;
    else if (width_cnt <= CW'(LONG_MAX))   cls_c = P3;
    else                                   cls_c = PERR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_class  <= P1;
      class_strobe <= 1'b0;
    end else begin
      class_strobe <= edge_det;
      if (edge_det) pulse_class <= cls_c;
    end
  end

endmodule

// File: rtl/spdif_in.sv
// S/PDIF receiver: preamble/biphase FSM, subframe assembly, parity, lock
// tracking and left/right pairing on top of the pulse timer.
module spdif_in
  import spdif_pkg::*;
#(
  parameter int SHORT_MIN  = DEF_SHORT_MIN,
  parameter int SHORT_MAX  = DEF_SHORT_MAX,
  parameter int MEDIUM_MAX = DEF_MEDIUM_MAX,
  parameter int LONG_MAX   = DEF_LONG_MAX,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spdif_async,
  output logic [23:0] audio_left,
  output logic [23:0] audio_right,
  output logic        data_valid,
  output logic        block_start,
  output logic [1:0]  validity,
  output logic        locked,
  output logic        parity_error
);

  localparam int LCW = $clog2(LOCK_COUNT + 1);

  typedef enum logic [2:0] {
    ST_SEARCH = 3'd0,
    ST_PRE    = 3'd1,
    ST_DATA   = 3'd2,
    ST_HALF   = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  pulse_class_t pulse_class;
  logic         class_strobe;
  logic         timeout;

  state_t       state_q, state_d;
  logic [1:0]   pre_idx_q, pre_idx_d;
  logic [5:0]   pre_seq_q, pre_seq_d;
  preamble_t    pre_kind_q, pre_kind_d;
  logic [4:0]   bit_cnt_q, bit_cnt_d;
  logic [31:4]  sub_sr;
  logic         sub_done_q;
  logic         shift_en, shift_bit, sub_end;
  pre_match_t   pre_hit;

  logic [LCW-1:0] lock_cnt;
  logic           left_pending;
  logic [23:0]    left_word;
  logic           left_v;
  logic           left_is_b;

  spdif_pulse_timer #(
    .SHORT_MIN  (SHORT_MIN),
    .SHORT_MAX  (SHORT_MAX),
    .MEDIUM_MAX (MEDIUM_MAX),
    .LONG_MAX   (LONG_MAX)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .spdif_async  (spdif_async),
    .pulse_class  (pulse_class),
    .class_strobe (class_strobe),
    .timeout      (timeout)
  );

  always_comb begin
    state_d    = state_q;
    pre_idx_d  = pre_idx_q;
    pre_seq_d  = pre_seq_q;
    pre_kind_d = pre_kind_q;
    bit_cnt_d  = bit_cnt_q;
    shift_en   = 1'b0;
    shift_bit  = 1'b0;
    sub_end    = 1'b0;
    pre_hit    = match_preamble({pre_seq_q, pulse_class});
    case (state_q)
      ST_SEARCH: begin
        if (class_strobe && pulse_class == P3) begin
          state_d   = ST_PRE;
          pre_idx_d = 2'd1;
          pre_seq_d = {4'b0000, P3};
        end
      end
      ST_PRE: begin
        if (timeout) begin
          state_d = ST_ERROR;
        end else if (class_strobe) begin
          if (pre_idx_q == 2'd3) begin
            if (pre_hit.hit) begin
              state_d    = ST_DATA;
              pre_kind_d = pre_hit.kind;
              bit_cnt_d  = 5'd4;
            end else begin
              state_d = ST_ERROR;
            end
          end else begin
            pre_seq_d = {pre_seq_q[3:0], pulse_class};
            pre_idx_d = pre_idx_q + 2'd1;
          end
        end
      end
      ST_DATA: begin
        if (timeout) begin
          state_d = ST_ERROR;
        end else if (class_strobe) begin
          case (pulse_class)
            P2:      shift_en = 1'b1;
            P1:      state_d  = ST_HALF;
            default: state_d  = ST_ERROR;
          endcase
        end
      end
      ST_HALF: begin
        if (timeout) begin
          state_d = ST_ERROR;
        end else if (class_strobe) begin
          if (pulse_class == P1) begin
            shift_en  = 1'b1;
            shift_bit = 1'b1;
            state_d   = ST_DATA;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_ERROR: state_d = ST_SEARCH;
      default:  state_d = ST_SEARCH;
    endcase
    // The pulse ending bit 31 also ends the subframe; the next pulse opens a preamble.
    if (shift_en) begin
      if (bit_cnt_q == 5'd31) begin
        sub_end   = 1'b1;
        state_d   = ST_PRE;
        pre_idx_d = 2'd0;
      end else begin
        bit_cnt_d = bit_cnt_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SEARCH;
      pre_idx_q  <= '0;
      pre_seq_q  <= '0;
      pre_kind_q <= PRE_B;
      bit_cnt_q  <= '0;
      sub_sr     <= '0;
      sub_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_idx_q  <= pre_idx_d;
      pre_seq_q  <= pre_seq_d;
      pre_kind_q <= pre_kind_d;
      bit_cnt_q  <= bit_cnt_d;
      sub_done_q <= sub_end;
      if (shift_en) sub_sr <= {shift_bit, sub_sr[31:5]};
    end
  end

  // data_valid is a one-cycle strobe with no back-pressure: the consumer must
  // take audio_left/right, validity and block_start in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      audio_left   <= '0;
      audio_right  <= '0;
      data_valid   <= 1'b0;
      block_start  <= 1'b0;
      validity     <= '0;
      locked       <= 1'b0;
      parity_error <= 1'b0;
      lock_cnt     <= '0;
      left_pending <= 1'b0;
      left_word    <= '0;
      left_v       <= 1'b0;
      left_is_b    <= 1'b0;
    end else begin
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      if (state_q == ST_ERROR) begin
        locked       <= 1'b0;
        lock_cnt     <= '0;
        left_pending <= 1'b0;
      end else if (sub_done_q) begin
        if (^sub_sr) begin
          parity_error <= 1'b1;
          locked       <= 1'b0;
          lock_cnt     <= '0;
          left_pending <= 1'b0;
        end else begin
          if (lock_cnt < LCW'(LOCK_COUNT)) lock_cnt <= lock_cnt + LCW'(1);
          if (lock_cnt >= LCW'(LOCK_COUNT - 1)) locked <= 1'b1;
          if (pre_kind_q != PRE_W) begin
            left_word    <= sub_sr[27:4];
            left_v       <= sub_sr[28];
            left_is_b    <= (pre_kind_q == PRE_B);
            left_pending <= 1'b1;
          end else begin
            left_pending <= 1'b0;
            // Pairing uses the lock state from before this subframe.
            if (left_pending && locked) begin
              audio_left  <= left_word;
              audio_right <= sub_sr[27:4];
              validity    <= {sub_sr[28], left_v};
              block_start <= left_is_b;
              data_valid  <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
